interrupt_ctrl: RTL and testbench
=================================

# interrupt_ctrl

- Parametrised interrupt and exception front-end for the MIPS-style CPU.
- Synchronises and edge-detects `NUM_IRQ` peripheral interrupt lines and keeps a maskable pending register.
- Arbitrates interrupts against illegal-instruction exceptions and drives the `IRQ` input of the decode control unit.
- Captures EPC and cause, and tracks kernel-mode entry and exit so only one event is taken per kernel visit.

## Interface
Parameters:
- `NUM_IRQ`, 4, number of interrupt sources, legal range 1..32.
- `DATA_W`, 32, PC/EPC width.

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `irq_src`  in  NUM_IRQ  raw peripheral interrupt lines; asynchronous, level.
- `en_wr`  in  1  writes `en_wdata` into the enable register.
- `en_wdata`  in  NUM_IRQ  new enable mask.
- `pend_clr`  in  1  write-1-to-clear strobe for pending bits.
- `pend_clr_mask`  in  NUM_IRQ  pending bits to clear.
- `pc31`  in  1  kernel bit of the PC currently in decode.
- `instr_valid`  in  1  decode instruction retires this cycle.
- `illegal`  in  1  decode instruction is unimplemented.
- `pc`  in  DATA_W  PC of the decode instruction.
- `irq`  out  1  interrupt request to the control unit.
- `cause`  out  8  bit7 = 1 for interrupt, 0 for exception; [6:0] = source index (0 for illegal instruction).
- `epc`  out  DATA_W  captured return PC.
- `pending`  out  NUM_IRQ  pending register.
- `enable`  out  NUM_IRQ  enable register.
- `in_service`  out  1  high when state is not IDLE.

## Operation
- Each source passes through a 2-flop synchroniser. A rising edge (sync2 & ~sync2_d) sets `pending[i]`.
- `pend_clr` clears the masked bits. If a set and a clear hit the same bit in the same cycle, the set wins.
- Winning source = lowest index of `pending & enable`.
- State machine:
  - IDLE → ENTER on take. Interrupt take: `irq & instr_valid`. Exception take: `~irq & illegal & ~pc31 & instr_valid`.
  - ENTER → KERNEL when `pc31 == 1`.
  - KERNEL → IDLE when `pc31 == 0`.
  - No other transitions.
- `irq = (state == IDLE) & ~pc31 & |(pending & enable)`. This is combinational from registered state, the pending/enable registers and `pc31`.
- Interrupt take:
  - `epc <= pc`.
  - `cause <= {1'b1, idx}`.
  - The winner's pending bit is cleared. This clear overrides a simultaneous new edge on the same bit.
- Exception take: `epc <= pc`, `cause <= 8'h00`.
- Priority: an interrupt beats an illegal instruction in the same cycle, matching control-unit priority. An illegal instruction while `pc31 == 1` is ignored.
- `epc` and `cause` hold until the next take. A take only happens from IDLE, so nested events cannot occur.
- The enable write is applied at the clock edge. The write never clears pending bits.

## Timing
- Reset values: all outputs and registers are 0. State = IDLE, `irq = 0`, `enable = 0`, synchronisers cleared.
- Reset mid-service returns the block to IDLE immediately and discards the pending bits.
- `irq_src` high before edge k gives: sync1 at k, sync2 at k+1, pending visible after edge k+2. `irq` rises in the same cycle if enabled and `~pc31`.
- Take: `epc`, `cause` and the state update at the edge where `irq & instr_valid`. `irq` is low from the next cycle.
- `irq` stays asserted across cycles with `instr_valid = 0` until a take.
- Minimum source pulse is 2 clock periods. Shorter pulses may be lost.
- A held-high source produces exactly one pending event.

## Structure
- Package `irq_pkg`:
  - state enum `irq_state_t` {IDLE, ENTER, KERNEL}.
  - constants `CAUSE_IRQ_BIT = 7` and `EXC_ILLEGAL = 7'd0`.
  - priority-encoder function `lowest_set`.
- Sub-module `irq_sync_edge`: 2-flop synchroniser plus edge pulse, one bit wide, instantiated `NUM_IRQ` times via generate.

## Test plan
- Reset, then `enable = 4'b0110`; pulse `irq_src[2]` for 3 cycles with `pc31 = 0`, `pc = 32'h0000_0040`. Required: `pending[2]` rises 3 edges after the pulse; `irq = 1`; on `instr_valid`, `epc = 32'h40`, `cause = 8'h82`, `pending[2] = 0`, `irq = 0`.
- Sources 1 and 2 pending together, both enabled. Required: `cause = 8'h81`; after kernel exit (`pc31` 1 → 0), `irq` reasserts and the take gives `cause = 8'h82`.
- `illegal = 1` with `pc31 = 0`, `pc = 32'h0000_0100`, nothing pending. Required: `epc = 32'h100`, `cause = 8'h00`, state ENTER then KERNEL when `pc31 = 1`. Repeat with `pc31 = 1`: no take.
- `illegal` and enabled pending source 0 in the same cycle. Required: interrupt taken, `cause = 8'h80`.
- `pend_clr` with mask `4'b0001` in the same cycle as a new source-0 edge. Required: `pending[0]` stays 1. Source 3 pending but `enable[3] = 0`: `irq` stays 0.
- Assert `reset` while in KERNEL. Required: state IDLE, all outputs 0; after release, no spurious `irq`.

Source files
------------

// File: rtl/irq_pkg.sv
// Shared types, constants and helpers for the interrupt/exception front-end.
package irq_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ENTER  = 2'd1,
    KERNEL = 2'd2
  } irq_state_t;

  localparam int         CAUSE_IRQ_BIT = 7;
  localparam logic [6:0] EXC_ILLEGAL   = 7'd0;

  // Index of the lowest set bit; 0 when the vector is empty.
  function automatic logic [6:0] lowest_set(input logic [31:0] vec);
    logic [6:0] idx;
    idx = '0;
    for (int i = 31; i >= 0; i--) begin
      if (vec[i]) idx = 7'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/irq_sync_edge.sv
// Two-flop synchroniser for one asynchronous level input, followed by a
// history flop that turns a synchronised low-to-high transition into a
// single-cycle pulse.
module irq_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic rise
);

  logic sync1_d, sync1_q;
  logic sync2_d, sync2_q;
  logic hist_d,  hist_q;

  // Next values of the synchroniser chain.
  always_comb begin
    sync1_d = async_in;
    sync2_d = sync1_q;
    hist_d  = sync2_q;
  end

  // Synchroniser and history registers.
  // NOTE: non-blocking assignments in clocked blocks so every flop samples
  // the pre-edge value of its neighbour; blocking here would collapse the chain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      hist_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      hist_q  <= hist_d;
    end
  end

  assign rise = sync2_q & ~hist_q;

endmodule

// File: rtl/interrupt_ctrl.sv
// Interrupt and exception front-end: synchronises peripheral lines, keeps a
// maskable pending register, arbitrates against illegal-instruction
// exceptions and records EPC/cause once per kernel visit.
module interrupt_ctrl
  import irq_pkg::*;
#(
  parameter int NUM_IRQ = 4,
  parameter int DATA_W  = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] irq_src,
  input  logic               en_wr,
  input  logic [NUM_IRQ-1:0] en_wdata,
  input  logic               pend_clr,
  input  logic [NUM_IRQ-1:0] pend_clr_mask,
  input  logic               pc31,
  input  logic               instr_valid,
  input  logic               illegal,
  input  logic [DATA_W-1:0]  pc,
  output logic               irq,
  output logic [7:0]         cause,
  output logic [DATA_W-1:0]  epc,
  output logic [NUM_IRQ-1:0] pending,
  output logic [NUM_IRQ-1:0] enable,
  output logic               in_service
);

  logic [NUM_IRQ-1:0] rise;
  logic [NUM_IRQ-1:0] active;
  logic [NUM_IRQ-1:0] win_onehot;
  logic [31:0]        active_ext;
  logic [6:0]         win_idx;
  logic               irq_w;
  logic               int_take;
  logic               exc_take;

  logic [NUM_IRQ-1:0] pend_d, pend_q;
  logic [NUM_IRQ-1:0] en_d,   en_q;
  irq_state_t         state_d, state_q;
  logic [7:0]         cause_d, cause_q;
  logic [DATA_W-1:0]  epc_d,   epc_q;

  // One synchroniser/edge detector per source.
  for (genvar i = 0; i < NUM_IRQ; i++) begin : g_sync
    irq_sync_edge u_sync (
      .clk      (clk),
      .reset    (reset),
      .async_in (irq_src[i]),
      .rise     (rise[i])
    );
  end

  // Arbitration: lowest enabled pending source wins; interrupt beats exception.
  always_comb begin
    active     = pend_q & en_q;
    win_onehot = active & (-active);
    active_ext = '0;
    active_ext[NUM_IRQ-1:0] = active;
    win_idx    = lowest_set(active_ext);
    irq_w      = (state_q == IDLE) & ~pc31 & (|active);
    int_take   = irq_w & instr_valid;
    exc_take   = (state_q == IDLE) & ~irq_w & illegal & ~pc31 & instr_valid;
  end

  // Pending/enable update: clear, then new edges (set wins), then the taken
  // winner is retired, which overrides a same-cycle edge on that bit.
  // NOTE: every always_comb output starts from a default so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    en_d   = en_wr ? en_wdata : en_q;
    pend_d = pend_q;
    if (pend_clr) pend_d = pend_d & ~pend_clr_mask;
    pend_d = pend_d | rise;
    if (int_take) pend_d = pend_d & ~win_onehot;
  end

  // Kernel-visit state machine: one take per visit, exit on return to user PC.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (int_take || exc_take) state_d = ENTER;
      ENTER:   if (pc31)                 state_d = KERNEL;
      KERNEL:  if (!pc31)                state_d = IDLE;
      default:                           state_d = IDLE;
    endcase
  end

  // EPC/cause capture on a take; held otherwise.
  always_comb begin
    epc_d   = epc_q;
    cause_d = cause_q;
    if (int_take) begin
      epc_d   = pc;
      cause_d = '0;
      cause_d[CAUSE_IRQ_BIT]   = 1'b1;
      cause_d[6:0]             = win_idx;
    end else if (exc_take) begin
      epc_d   = pc;
      cause_d = {1'b0, EXC_ILLEGAL};
    end
  end

  // Architectural registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_q  <= '0;
      en_q    <= '0;
      state_q <= IDLE;
      cause_q <= '0;
      epc_q   <= '0;
    end else begin
      pend_q  <= pend_d;
      en_q    <= en_d;
      state_q <= state_d;
      cause_q <= cause_d;
      epc_q   <= epc_d;
    end
  end

  assign irq        = irq_w;
  assign cause      = cause_q;
  assign epc        = epc_q;
  assign pending    = pend_q;
  assign enable     = en_q;
  assign in_service = (state_q != IDLE);

endmodule

// File: tb/tb_interrupt_ctrl.sv
// Directed bench for interrupt_ctrl: a per-cycle vector table for the main
// flows plus hand-written sequences for clear/set races, masking and reset.
module tb_interrupt_ctrl;

  localparam int NUM_IRQ = 4;
  localparam int DATA_W  = 32;

  logic               clk;
  logic               reset;
  logic [NUM_IRQ-1:0] irq_src;
  logic               en_wr;
  logic [NUM_IRQ-1:0] en_wdata;
  logic               pend_clr;
  logic [NUM_IRQ-1:0] pend_clr_mask;
  logic               pc31;
  logic               instr_valid;
  logic               illegal;
  logic [DATA_W-1:0]  pc;
  logic               irq;
  logic [7:0]         cause;
  logic [DATA_W-1:0]  epc;
  logic [NUM_IRQ-1:0] pending;
  logic [NUM_IRQ-1:0] enable;
  logic               in_service;

  int checks   = 0;
  int failures = 0;

  interrupt_ctrl #(.NUM_IRQ(NUM_IRQ), .DATA_W(DATA_W)) dut (
    .clk           (clk),
    .reset         (reset),
    .irq_src       (irq_src),
    .en_wr         (en_wr),
    .en_wdata      (en_wdata),
    .pend_clr      (pend_clr),
    .pend_clr_mask (pend_clr_mask),
    .pc31          (pc31),
    .instr_valid   (instr_valid),
    .illegal       (illegal),
    .pc            (pc),
    .irq           (irq),
    .cause         (cause),
    .epc           (epc),
    .pending       (pending),
    .enable        (enable),
    .in_service    (in_service)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    string       name;
    logic [3:0]  src;
    logic        wr;
    logic [3:0]  wdata;
    logic        p31;
    logic        valid;
    logic        ill;
    logic [31:0] pcv;
    logic        e_irq;
    logic [7:0]  e_cause;
    logic [31:0] e_epc;
    logic [3:0]  e_pend;
    logic [3:0]  e_en;
    logic        e_svc;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string n, logic [3:0] s, logic w, logic [3:0] wd,
                              logic p, logic v, logic il, logic [31:0] pcv,
                              logic ei, logic [7:0] ec, logic [31:0] ee,
                              logic [3:0] ep, logic [3:0] en, logic es);
    vec_t r;
    r.name = n; r.src = s; r.wr = w; r.wdata = wd; r.p31 = p; r.valid = v;
    r.ill = il; r.pcv = pcv; r.e_irq = ei; r.e_cause = ec; r.e_epc = ee;
    r.e_pend = ep; r.e_en = en; r.e_svc = es;
    return r;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_all(string tag, logic e_irq, logic [7:0] e_cause,
                           logic [31:0] e_epc, logic [3:0] e_pend,
                           logic [3:0] e_en, logic e_svc);
    check({tag, ".irq"},        32'(irq),        32'(e_irq));
    check({tag, ".cause"},      32'(cause),      32'(e_cause));
    check({tag, ".epc"},        epc,             e_epc);
    check({tag, ".pending"},    32'(pending),    32'(e_pend));
    check({tag, ".enable"},     32'(enable),     32'(e_en));
    check({tag, ".in_service"}, 32'(in_service), 32'(e_svc));
  endtask

  // Advance one rising edge and settle a little past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; irq_src = '0; en_wr = 1'b0; en_wdata = '0; pend_clr = 1'b0;
    pend_clr_mask = '0; pc31 = 1'b0; instr_valid = 1'b0; illegal = 1'b0; pc = '0;

    //            name         src w  wd  p v i  pc       irq cause  epc     pnd en svc
    vecs.push_back(mk("en_wr",     4'h0,1,4'h6,0,0,0,32'h40,  0,8'h00,32'h0,  4'h0,4'h6,0));
    vecs.push_back(mk("sync1",     4'h4,0,4'h0,0,0,0,32'h40,  0,8'h00,32'h0,  4'h0,4'h6,0));
    vecs.push_back(mk("sync2",     4'h4,0,4'h0,0,0,0,32'h40,  0,8'h00,32'h0,  4'h0,4'h6,0));
    vecs.push_back(mk("pend2",     4'h4,0,4'h0,0,0,0,32'h40,  1,8'h00,32'h0,  4'h4,4'h6,0));
    vecs.push_back(mk("irq_hold",  4'h0,0,4'h0,0,0,0,32'h40,  1,8'h00,32'h0,  4'h4,4'h6,0));
    vecs.push_back(mk("take2",     4'h0,0,4'h0,0,1,0,32'h40,  0,8'h82,32'h40, 4'h0,4'h6,1));
    vecs.push_back(mk("kern1",     4'h0,0,4'h0,1,0,0,32'h40,  0,8'h82,32'h40, 4'h0,4'h6,1));
    vecs.push_back(mk("exit1",     4'h0,0,4'h0,0,0,0,32'h40,  0,8'h82,32'h40, 4'h0,4'h6,0));
    vecs.push_back(mk("exc_take",  4'h0,0,4'h0,0,1,1,32'h100, 0,8'h00,32'h100,4'h0,4'h6,1));
    vecs.push_back(mk("enter_hold",4'h0,0,4'h0,0,0,0,32'h100, 0,8'h00,32'h100,4'h0,4'h6,1));
    vecs.push_back(mk("exc_kern",  4'h0,0,4'h0,1,0,0,32'h100, 0,8'h00,32'h100,4'h0,4'h6,1));
    vecs.push_back(mk("kern_ill",  4'h0,0,4'h0,1,1,1,32'h200, 0,8'h00,32'h100,4'h0,4'h6,1));
    vecs.push_back(mk("exit2",     4'h0,0,4'h0,0,0,0,32'h200, 0,8'h00,32'h100,4'h0,4'h6,0));
    vecs.push_back(mk("ill_pc31",  4'h0,0,4'h0,1,1,1,32'h300, 0,8'h00,32'h100,4'h0,4'h6,0));
    vecs.push_back(mk("en7",       4'h1,1,4'h7,0,0,0,32'h300, 0,8'h00,32'h100,4'h0,4'h7,0));
    vecs.push_back(mk("src0_s2",   4'h1,0,4'h0,0,0,0,32'h300, 0,8'h00,32'h100,4'h0,4'h7,0));
    vecs.push_back(mk("pend0",     4'h1,0,4'h0,0,0,0,32'h300, 1,8'h00,32'h100,4'h1,4'h7,0));
    vecs.push_back(mk("irq_vs_ill",4'h1,0,4'h0,0,1,1,32'h500, 0,8'h80,32'h500,4'h0,4'h7,1));
    vecs.push_back(mk("kern3",     4'h1,0,4'h0,1,0,0,32'h500, 0,8'h80,32'h500,4'h0,4'h7,1));
    vecs.push_back(mk("held_once", 4'h0,0,4'h0,0,0,0,32'h500, 0,8'h80,32'h500,4'h0,4'h7,0));

    // Reset state.
    #2;
    check_all("reset", 1'b0, 8'h00, 32'h0, 4'h0, 4'h0, 1'b0);
    step();
    #2 reset = 1'b0;

    // Table-driven main flows: inputs for one cycle, outputs after its edge.
    foreach (vecs[i]) begin
      irq_src = vecs[i].src; en_wr = vecs[i].wr; en_wdata = vecs[i].wdata;
      pc31 = vecs[i].p31; instr_valid = vecs[i].valid; illegal = vecs[i].ill;
      pc = vecs[i].pcv;
      step();
      check_all(vecs[i].name, vecs[i].e_irq, vecs[i].e_cause, vecs[i].e_epc,
                vecs[i].e_pend, vecs[i].e_en, vecs[i].e_svc);
    end
    irq_src = '0; en_wr = 1'b0; pc31 = 1'b0; instr_valid = 1'b0; illegal = 1'b0;

    // Two sources pending together: lowest index first, then the other after exit.
    en_wr = 1'b1; en_wdata = 4'h6; irq_src = 4'h6;
    step();
    en_wr = 1'b0;
    step();
    step();
    check("dual.pending", 32'(pending), 32'h6);
    check("dual.irq",     32'(irq),     32'h1);
    irq_src = '0; instr_valid = 1'b1; pc = 32'h600;
    step();
    check("dual.cause1",  32'(cause),   32'h81);
    check("dual.epc1",    epc,          32'h600);
    check("dual.pend1",   32'(pending), 32'h4);
    check("dual.irq_off", 32'(irq),     32'h0);
    instr_valid = 1'b0; pc31 = 1'b1;
    step();
    check("dual.kern_irq", 32'(irq), 32'h0);
    pc31 = 1'b0;
    step();
    check("dual.reassert", 32'(irq), 32'h1);
    instr_valid = 1'b1; pc = 32'h700;
    step();
    check("dual.cause2",  32'(cause),   32'h82);
    check("dual.epc2",    epc,          32'h700);
    check("dual.pend2",   32'(pending), 32'h0);
    instr_valid = 1'b0; pc31 = 1'b1;
    step();
    pc31 = 1'b0;
    step();
    check("dual.idle", 32'(in_service), 32'h0);

    // Clear and new edge on the same bit: the set wins. Source 0 is masked.
    irq_src = 4'h1;
    step();
    step();
    pend_clr = 1'b1; pend_clr_mask = 4'h1;
    step();
    check("race.pending0", 32'(pending), 32'h1);
    check("race.masked_irq", 32'(irq), 32'h0);
    step();
    check("clr.pending0", 32'(pending), 32'h0);
    pend_clr = 1'b0; pend_clr_mask = '0; irq_src = 4'h8;
    step();
    step();
    step();
    check("mask3.pending", 32'(pending), 32'h8);
    check("mask3.irq",     32'(irq),     32'h0);

    // Enable source 3, take it, enter kernel, then reset mid-service.
    irq_src = '0; en_wr = 1'b1; en_wdata = 4'h8;
    step();
    check("svc3.irq", 32'(irq), 32'h1);
    en_wr = 1'b0; instr_valid = 1'b1; pc = 32'h800;
    step();
    check("svc3.cause", 32'(cause), 32'h83);
    check("svc3.epc",   epc,        32'h800);
    instr_valid = 1'b0; pc31 = 1'b1;
    step();
    check("svc3.kernel", 32'(in_service), 32'h1);
    #2 reset = 1'b1;
    #1;
    check_all("mid_reset", 1'b0, 8'h00, 32'h0, 4'h0, 4'h0, 1'b0);
    #2 reset = 1'b0;
    pc31 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check("post_reset.irq",     32'(irq),     32'h0);
      check("post_reset.pending", 32'(pending), 32'h0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
